// File: rtl/ysyx_22041211_axi_sram.sv
`timescale 1ns/1ps
// AXI-lite slave SRAM for the LSU data path.
// Word-addressed array with independent read and write FSMs, each with a
// programmable response latency, and OKAY/SLVERR decode on the byte address.
//
// Read FSM
//   state  | meaning
//   R_IDLE | ready for AR
//   R_WAIT | latency down-counter running
//   R_RESP | r_valid_o high, data/resp held until r_ready_i
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W (either order or together)
//   W_WAIT | latency down-counter running
//   W_RESP | bkwd_valid_o high, resp held until bkwd_ready_i
module ysyx_22041211_axi_sram #(
  parameter int                  DATA_LEN   = 32,
  parameter int                  ADDR_LEN   = 32,
  parameter int                  DEPTH      = 1024,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR  = ADDR_LEN'(32'h8000_0000),
  parameter int                  RD_LATENCY = 2,
  parameter int                  WR_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] addr_r_addr_i,
  input  logic                addr_r_valid_i,
  output logic                addr_r_ready_o,
  output logic [DATA_LEN-1:0] r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  input  logic [ADDR_LEN-1:0] addr_w_addr_i,
  input  logic                addr_w_valid_i,
  output logic                addr_w_ready_o,
  input  logic [DATA_LEN-1:0] w_data_i,
  input  logic [3:0]          w_strb_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  output logic [1:0]          bkwd_resp_o,
  output logic                bkwd_valid_o,
  input  logic                bkwd_ready_i
);

  localparam int                IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CW       = 16;
  localparam int                AW1      = ADDR_LEN + 1;
  localparam logic [AW1-1:0]    LP_LIMIT = {1'b0, BASE_ADDR} + AW1'(4 * DEPTH);
  localparam logic [1:0]        RESP_OK  = 2'b00;
  localparam logic [1:0]        RESP_ERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  // Extended-width compare so BASE_ADDR + 4*DEPTH cannot wrap.
  function automatic logic f_in_range(input logic [ADDR_LEN-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LP_LIMIT);
  endfunction

  function automatic logic [IW-1:0] f_idx(input logic [ADDR_LEN-1:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_LEN-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------- read side
  rd_state_t           r_rd_state;
  rd_state_t           w_rd_state_nxt;
  logic [CW-1:0]       r_rd_cnt;
  logic [CW-1:0]       w_rd_cnt_nxt;
  logic [ADDR_LEN-1:0] r_rd_addr;
  logic                w_ar_hs;
  logic                w_rd_capture;
  logic [ADDR_LEN-1:0] w_rd_addr_cap;
  logic                w_rd_in_range;
  logic [IW-1:0]       w_rd_idx;
  logic [DATA_LEN-1:0] w_rd_word;
  logic [DATA_LEN-1:0] w_rd_shift;

  assign addr_r_ready_o = !rst && (r_rd_state == R_IDLE);
  assign r_valid_o      = (r_rd_state == R_RESP);
  assign w_ar_hs        = addr_r_ready_o && addr_r_valid_i;

  // With RD_LATENCY=1 the capture happens on the handshake edge itself,
  // so the address comes straight from the port rather than the latch.
  assign w_rd_addr_cap  = (r_rd_state == R_IDLE) ? addr_r_addr_i : r_rd_addr;
  assign w_rd_in_range  = f_in_range(w_rd_addr_cap);
  assign w_rd_idx       = f_idx(w_rd_addr_cap);
  assign w_rd_word      = r_mem[w_rd_idx];
  assign w_rd_shift     = w_rd_word >> {w_rd_addr_cap[1:0], 3'b000};

  // Read FSM next state and latency counter.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_rd_capture   = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (w_ar_hs) begin
          if (RD_LATENCY == 1) begin
            w_rd_state_nxt = R_RESP;
            w_rd_capture   = 1'b1;
          end else begin
            w_rd_state_nxt = R_WAIT;
            w_rd_cnt_nxt   = CW'(RD_LATENCY - 1);
          end
        end
      end
      R_WAIT: begin
        w_rd_cnt_nxt = r_rd_cnt - CW'(1);
        if (r_rd_cnt == CW'(1)) begin
          w_rd_state_nxt = R_RESP;
          w_rd_capture   = 1'b1;
        end
      end
      R_RESP: begin
        if (r_ready_i) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Read state, address latch and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= '0;
      r_rd_addr  <= '0;
      r_data_o   <= '0;
      r_resp_o   <= RESP_OK;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      if (w_ar_hs) r_rd_addr <= addr_r_addr_i;
      if (w_rd_capture) begin
        r_data_o <= w_rd_in_range ? w_rd_shift : '0;
        r_resp_o <= w_rd_in_range ? RESP_OK : RESP_ERR;
      end
    end
  end

  // --------------------------------------------------------------- write side
  wr_state_t           r_wr_state;
  wr_state_t           w_wr_state_nxt;
  logic [CW-1:0]       r_wr_cnt;
  logic [CW-1:0]       w_wr_cnt_nxt;
  logic                r_aw_got;
  logic                r_w_got;
  logic [ADDR_LEN-1:0] r_aw_addr;
  logic [DATA_LEN-1:0] r_w_data;
  logic [3:0]          r_w_strb;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_wr_commit;
  logic [ADDR_LEN-1:0] w_wr_addr_eff;
  logic [DATA_LEN-1:0] w_wr_data_eff;
  logic [3:0]          w_wr_strb_eff;
  logic                w_wr_in_range;
  logic [IW-1:0]       w_wr_idx;
  logic [3:0]          w_be;
  logic [DATA_LEN-1:0] w_wdata_sh;
  logic                w_mem_we;

  assign addr_w_ready_o = !rst && (r_wr_state == W_IDLE) && !r_aw_got;
  assign w_ready_o      = !rst && (r_wr_state == W_IDLE) && !r_w_got;
  assign bkwd_valid_o   = (r_wr_state == W_RESP);
  assign w_aw_hs        = addr_w_ready_o && addr_w_valid_i;
  assign w_w_hs         = w_ready_o && w_valid_i;

  // Channels not yet latched are taken from the ports so a commit on the
  // completing handshake edge (WR_LATENCY=1) sees the arriving beat.
  assign w_wr_addr_eff  = r_aw_got ? r_aw_addr : addr_w_addr_i;
  assign w_wr_data_eff  = r_w_got  ? r_w_data  : w_data_i;
  assign w_wr_strb_eff  = r_w_got  ? r_w_strb  : w_strb_i;
  assign w_wr_in_range  = f_in_range(w_wr_addr_eff);
  assign w_wr_idx       = f_idx(w_wr_addr_eff);

  // Shifting strobes inside 4 bits drops bytes that would cross the word.
  assign w_be           = 4'(w_wr_strb_eff << w_wr_addr_eff[1:0]);
  assign w_wdata_sh     = w_wr_data_eff << {w_wr_addr_eff[1:0], 3'b000};
  assign w_mem_we       = w_wr_commit && w_wr_in_range && !rst;

  // Write FSM next state and latency counter.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_wr_commit    = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
          if (WR_LATENCY == 1) begin
            w_wr_state_nxt = W_RESP;
            w_wr_commit    = 1'b1;
          end else begin
            w_wr_state_nxt = W_WAIT;
            w_wr_cnt_nxt   = CW'(WR_LATENCY - 1);
          end
        end
      end
      W_WAIT: begin
        w_wr_cnt_nxt = r_wr_cnt - CW'(1);
        if (r_wr_cnt == CW'(1)) begin
          w_wr_state_nxt = W_RESP;
          w_wr_commit    = 1'b1;
        end
      end
      W_RESP: begin
        if (bkwd_ready_i) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Write state, AW/W latches and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state  <= W_IDLE;
      r_wr_cnt    <= '0;
      r_aw_got    <= 1'b0;
      r_w_got     <= 1'b0;
      r_aw_addr   <= '0;
      r_w_data    <= '0;
      r_w_strb    <= '0;
      bkwd_resp_o <= RESP_OK;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      if (w_aw_hs) begin
        r_aw_got  <= 1'b1;
        r_aw_addr <= addr_w_addr_i;
      end
      if (w_w_hs) begin
        r_w_got  <= 1'b1;
        r_w_data <= w_data_i;
        r_w_strb <= w_strb_i;
      end
      if ((r_wr_state == W_RESP) && bkwd_ready_i) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end
      if (w_wr_commit) bkwd_resp_o <= w_wr_in_range ? RESP_OK : RESP_ERR;
    end
  end

  // Array byte writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_we && w_be[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
    end
  end

endmodule

// File: doc/ysyx_22041211_axi_sram.md
# ysyx_22041211_axi_sram

AXI-lite slave memory that answers the load/store traffic issued by the core's LSU, with its five channels (AR, R, AW, W, B) named as the LSU's with directions reversed. It holds a word-addressed RAM with programmable read and write latency. It sits on the data side of the core between the LSU and the bus. It returns OKAY or SLVERR on every accepted transaction.

## Interface
- DATA_LEN, 32, data width; fixed at 32.
- ADDR_LEN, 32, address width.
- DEPTH, 1024, number of 32-bit words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LATENCY, 2, cycles from AR handshake edge to r_valid_o; must be ≥1.
- WR_LATENCY, 2, cycles from edge where both AW and W are held to bkwd_valid_o; must be ≥1.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- addr_r_addr_i  in  ADDR_LEN  read byte address.
- addr_r_valid_i  in  1  read address valid.
- addr_r_ready_o  out  1  read address accepted.
- r_data_o  out  DATA_LEN  read data.
- r_resp_o  out  2  2'b00 OKAY, 2'b10 SLVERR.
- r_valid_o  out  1  read data valid.
- r_ready_i  in  1  master accepts read data.
- addr_w_addr_i  in  ADDR_LEN  write byte address.
- addr_w_valid_i  in  1  write address valid.
- addr_w_ready_o  out  1  write address accepted.
- w_data_i  in  DATA_LEN  write data, low-aligned.
- w_strb_i  in  4  byte strobes, low-aligned.
- w_valid_i  in  1  write data valid.
- w_ready_o  out  1  write data accepted.
- bkwd_resp_o  out  2  write response, encoding as r_resp_o.
- bkwd_valid_o  out  1  write response valid.
- bkwd_ready_i  in  1  master accepts write response.

## Operation
- Address decode
  - In range when BASE_ADDR ≤ addr < BASE_ADDR+4*DEPTH.
  - Word index = (addr-BASE_ADDR)>>2; lane offset o = addr[1:0].
  - Out of range gives SLVERR: read data 0, no array write.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: addr_r_ready_o=1. On handshake, latch address, load counter with RD_LATENCY-1, go to R_WAIT. If RD_LATENCY=1, go directly to R_RESP.
  - R_WAIT: counter decrements each cycle; at 0 go to R_RESP.
  - On entry to R_RESP, register r_data_o = word >> (8*o), zero-filled, and register r_resp_o.
  - R_RESP: r_valid_o=1; data and resp stay stable until r_ready_i, then go to R_IDLE (r_valid_o=0).
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: addr_w_ready_o=1 while AW not yet latched; w_ready_o=1 while W not yet latched. AW and W may arrive in either order or the same cycle.
  - Once both are latched, load counter with WR_LATENCY-1 and go to W_WAIT (W_RESP if latency is 1). Counter behaves as in the read FSM.
  - On the edge entering W_RESP, commit the write: for i in 0..3 with w_strb[i]=1 and o+i ≤ 3, byte (o+i) of the word ← w_data[8i+7:8i]. Bytes that would cross the word boundary are dropped.
  - W_RESP: bkwd_valid_o=1 with stable bkwd_resp_o until bkwd_ready_i, then go to W_IDLE.
- Read and write FSMs are independent and may be active at once.
- Same-word collision at one edge: the read samples the old word (write commit happens in parallel with read data capture).
- Array contents are not reset.

## Timing
- Reset values of outputs:
  - all ready outputs 0 while rst=1, 1 from the first cycle after release;
  - r_valid_o=0, bkwd_valid_o=0, r_data_o=0, r_resp_o=0, bkwd_resp_o=0.
- Reset mid-transaction: FSMs return to IDLE immediately. No response is issued; a latched but uncommitted write is discarded.
- Read latency: AR handshake at edge N → r_valid_o high in the cycle after edge N+RD_LATENCY-1. RD_LATENCY=1 means valid the cycle after the handshake.
- Throughput: one read per RD_LATENCY+1 cycles when r_ready_i is held high; writes likewise. A new AR is not accepted in the cycle its R handshake completes.
- Valid outputs never drop without the matching ready; a holding master sees no change in data or resp.

## Test plan
- Single-word write and read: AW=0x8000_0010, W=0xDEADBEEF, strb 4'hF; then AR same address → bkwd_resp 00; r_data 0xDEADBEEF, r_valid exactly RD_LATENCY cycles after the AR handshake.
- Sub-word store and load: SB 0xAB at 0x8000_0013 (strb 4'h1), then read 0x8000_0010 → 0xABADBEEF; read 0x8000_0013 → 0x000000AB.
- W one cycle before AW, then r_ready_i/bkwd_ready_i held low for 5 cycles → write commits once, valid held 5 cycles with data stable, single response.
- Out-of-range accesses: read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH=1024) → resp 2'b10, r_data 0, array unchanged.
- Concurrent same-word read and write with equal latency, both handshakes on the same edge → read returns the old word; a later read returns the new word.
- rst asserted asynchronously during R_WAIT and W_WAIT → valids and readies drop at once, no response, write not committed; a normal transaction succeeds after release.
